// File: rtl/i2s_sched_pkg.sv
// Shared types and helpers for the I2S frame-rate sample scheduler.
// Mode encoding matches the 2-bit mode port; sat_add16 is the mixer's clipping adder.
package i2s_sched_pkg;

  localparam int unsigned SAMPLE_W = 16;

  typedef enum logic [1:0] {
    MODE_SRC0 = 2'd0,
    MODE_SRC1 = 2'd1,
    MODE_MIX  = 2'd2,
    MODE_MUTE = 2'd3
  } mode_e;

  function automatic logic [SAMPLE_W-1:0] sat_add16(input logic [SAMPLE_W-1:0] a,
                                                    input logic [SAMPLE_W-1:0] b);
    logic [SAMPLE_W:0] sum;
    sum = {a[SAMPLE_W-1], a} + {b[SAMPLE_W-1], b};
    // Sign bit and carry-out disagree only on overflow; clip toward the overflow side.
    if (sum[SAMPLE_W] != sum[SAMPLE_W-1])
      return sum[SAMPLE_W] ? {1'b1, {(SAMPLE_W-1){1'b0}}} : {1'b0, {(SAMPLE_W-1){1'b1}}};
    return sum[SAMPLE_W-1:0];
  endfunction

endpackage

// File: rtl/sample_slot.sv
// One-entry stereo holding buffer with valid/ready handshake.
// Consume empties a full slot; a push into an empty slot on a consume cycle is kept.
module sample_slot
  import i2s_sched_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                valid,
  input  logic                consume,
  input  logic [SAMPLE_W-1:0] push_left,
  input  logic [SAMPLE_W-1:0] push_right,
  output logic                ready,
  output logic                full,
  output logic [SAMPLE_W-1:0] left,
  output logic [SAMPLE_W-1:0] right
);

  logic xfer;
  logic full_next;

  assign xfer      = valid & ready;
  assign full_next = xfer | (full & ~consume);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full  <= 1'b0;
      ready <= 1'b0;
      left  <= '0;
      right <= '0;
    end else begin
      full  <= full_next;
      ready <= ~full_next;
      if (xfer) begin
        left  <= push_left;
        right <= push_right;
      end
    end
  end

endmodule

// File: rtl/i2s_sample_scheduler.sv
// Frame-rate scheduler: frame timebase, sample-request pulse, per-frame source
// select/mix/mute into registered output words, and underrun status.
module i2s_sample_scheduler
  import i2s_sched_pkg::*;
#(
  parameter int unsigned FRAME_CLKS = 512,
  parameter int unsigned REQ_LEAD   = 64,
  parameter int unsigned UCNT_W     = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          mode,
  input  logic                s0_valid,
  output logic                s0_ready,
  input  logic [SAMPLE_W-1:0] s0_left,
  input  logic [SAMPLE_W-1:0] s0_right,
  input  logic                s1_valid,
  output logic                s1_ready,
  input  logic [SAMPLE_W-1:0] s1_left,
  input  logic [SAMPLE_W-1:0] s1_right,
  output logic                sreq,
  output logic [SAMPLE_W-1:0] out_left,
  output logic [SAMPLE_W-1:0] out_right,
  output logic                out_load,
  output logic                underrun,
  output logic [UCNT_W-1:0]   underrun_cnt,
  input  logic                clr_status
);

  localparam int unsigned CNT_W = $clog2(FRAME_CLKS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_CLKS - 1);
  localparam logic [CNT_W-1:0] REQ_CNT  = CNT_W'(FRAME_CLKS - 1 - REQ_LEAD);

  logic [CNT_W-1:0]    cnt;
  logic                strobe;
  logic                s0_full, s1_full;
  logic [SAMPLE_W-1:0] s0_l, s0_r, s1_l, s1_r;
  logic [SAMPLE_W-1:0] sel_left, sel_right;
  logic                ur_event;

  assign strobe = (cnt == LAST_CNT);
  assign sreq   = (cnt == REQ_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= strobe ? '0 : cnt + CNT_W'(1);
  end

  sample_slot u_slot0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid     (s0_valid),
    .consume   (strobe),
    .push_left (s0_left),
    .push_right(s0_right),
    .ready     (s0_ready),
    .full      (s0_full),
    .left      (s0_l),
    .right     (s0_r)
  );

  sample_slot u_slot1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid     (s1_valid),
    .consume   (strobe),
    .push_left (s1_left),
    .push_right(s1_right),
    .ready     (s1_ready),
    .full      (s1_full),
    .left      (s1_l),
    .right     (s1_r)
  );

  // Slot full flags are the pre-transfer state, so a same-cycle push is not seen here.
  always_comb begin
    sel_left  = out_left;
    sel_right = out_right;
    ur_event  = 1'b0;
    case (mode_e'(mode))
      MODE_SRC0: begin
        if (s0_full) begin
          sel_left  = s0_l;
          sel_right = s0_r;
        end else begin
          ur_event = 1'b1;
        end
      end
      MODE_SRC1: begin
        if (s1_full) begin
          sel_left  = s1_l;
          sel_right = s1_r;
        end else begin
          ur_event = 1'b1;
        end
      end
      MODE_MIX: begin
        sel_left  = sat_add16(s0_full ? s0_l : '0, s1_full ? s1_l : '0);
        sel_right = sat_add16(s0_full ? s0_r : '0, s1_full ? s1_r : '0);
        ur_event  = ~s0_full | ~s1_full;
      end
      MODE_MUTE: begin
        sel_left  = '0;
        sel_right = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_left  <= '0;
      out_right <= '0;
      out_load  <= 1'b0;
    end else begin
      out_load <= strobe;
      if (strobe) begin
        out_left  <= sel_left;
        out_right <= sel_right;
      end
    end
  end

  // An underrun coinciding with clr_status restarts the count at one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else if (strobe && ur_event) begin
      underrun <= 1'b1;
      if (clr_status)            underrun_cnt <= UCNT_W'(1);
      else if (~&underrun_cnt)   underrun_cnt <= underrun_cnt + UCNT_W'(1);
    end else if (clr_status) begin
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end
  end

endmodule
